// File: rtl/regfile_multiport_clr.sv
// -----------------------------------------------------------------------------
// regfile_multiport_clr
//   Parametrised register file with one synchronous write port and NR
//   asynchronous read ports. Optional hardwired zero entry, optional
//   write-to-read bypass, and a sequential clear engine that zeroes one entry
//   per clock so the array can be wiped without a global reset.
//
// Ports
//   clk        system clock, rising-edge active
//   reset      synchronous active-high reset (zeroes array, idles the engine)
//   we         write enable
//   wad        write address (M bits)
//   din        write data (W bits)
//   rad        NR packed read addresses, port i at [i*M +: M]
//   dout       NR packed read data, port i at [i*W +: W]
//   clr_start  request a full sequential clear
//   busy       high while the clear engine is running
//   wr_drop    one-cycle pulse: a write was discarded because busy was high
// -----------------------------------------------------------------------------
module regfile_multiport_clr #(
   parameter int W        = 16,
   parameter int M        = 4,
   parameter int NR       = 3,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we,
   input  logic [M-1:0]    wad,
   input  logic [W-1:0]    din,
   input  logic [NR*M-1:0] rad,
   output logic [NR*W-1:0] dout,
   input  logic            clr_start,
   output logic            busy,
   output logic            wr_drop
);

   localparam int DEPTH = int'(32'd1 << M);
   localparam bit ZR    = (ZERO_REG != 32'sd0);
   localparam bit BP    = (BYPASS != 32'sd0);

   localparam logic [M-1:0] PTR_ZERO = {M{1'b0}};
   localparam logic [M-1:0] PTR_LAST = {M{1'b1}};
   localparam logic [M:0]   ONE_EXT  = {{M{1'b0}}, 1'b1};
   localparam logic [M-1:0] PTR_ONE  = ONE_EXT[M-1:0];

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t         state_r;
   state_t         state_nxt_s;
   logic [M-1:0]   ptr_r;
   logic [M-1:0]   ptr_nxt_s;
   logic           wr_drop_r;
   logic [W-1:0]   mem_r [DEPTH];

   logic           busy_s;
   logic           wad_is_zero_s;
   logic           wr_ok_s;

   assign busy_s        = (state_r == ST_CLEAR);
   assign wad_is_zero_s = (wad == PTR_ZERO);
   // Writes are accepted only while idle; the zero entry silently swallows them.
   assign wr_ok_s       = we & ~busy_s & ~(ZR & wad_is_zero_s);

   assign busy    = busy_s;
   assign wr_drop = wr_drop_r;

   // Clear-engine next-state and pointer logic
   always_comb begin
      state_nxt_s = state_r;
      ptr_nxt_s   = ptr_r;
      case (state_r)
         ST_IDLE: begin
            if (clr_start) begin
               state_nxt_s = ST_CLEAR;
               ptr_nxt_s   = PTR_ZERO;
            end else begin
               state_nxt_s = ST_IDLE;
               ptr_nxt_s   = ptr_r;
            end
         end
         ST_CLEAR: begin
            // clr_start is deliberately ignored here: no restart, no extension.
            if (ptr_r == PTR_LAST) begin
               state_nxt_s = ST_IDLE;
               ptr_nxt_s   = PTR_ZERO;
            end else begin
               state_nxt_s = ST_CLEAR;
               ptr_nxt_s   = ptr_r + PTR_ONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            ptr_nxt_s   = PTR_ZERO;
         end
      endcase
   end

   // Clear-engine state, pointer and drop-pulse registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         ptr_r     <= PTR_ZERO;
         wr_drop_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         ptr_r     <= ptr_nxt_s;
         wr_drop_r <= we & busy_s;
      end
   end

   // Storage array: reset wipe, clear-engine wipe, or normal write
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {W{1'b0}};
         end
      end else if (busy_s) begin
         mem_r[ptr_r] <= {W{1'b0}};
      end else if (wr_ok_s) begin
         mem_r[wad] <= din;
      end
   end

   for (genvar g = 0; g < NR; g++) begin : g_rd
      logic [M-1:0] addr_s;
      logic [W-1:0] data_s;

      assign addr_s = rad[g*M +: M];

      // Per-port asynchronous read mux: zero entry, then bypass, then array
      always_comb begin
         data_s = {W{1'b0}};
         if (ZR && (addr_s == PTR_ZERO)) begin
            data_s = {W{1'b0}};
         end else if (BP && we && !busy_s && (addr_s == wad)) begin
            data_s = din;
         end else begin
            data_s = mem_r[addr_s];
         end
      end

      assign dout[g*W +: W] = data_s;
   end

endmodule

// File: tb/tb_regfile_multiport_clr.sv
module tb_regfile_multiport_clr;

   localparam int W     = 16;
   localparam int M     = 4;
   localparam int NR    = 3;
   localparam int DEPTH = 16;

   logic            clk;
   logic            reset;
   logic            we;
   logic [M-1:0]    wad;
   logic [W-1:0]    din;
   logic [NR*M-1:0] rad;
   logic [NR*W-1:0] dout;
   logic            clr_start;
   logic            busy;
   logic            wr_drop;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: contents plus "how many entries the clear still has to wipe"
   logic [W-1:0] mem_m [DEPTH];
   int           clr_left;
   logic         drop_m;

   regfile_multiport_clr #(.W(W), .M(M), .NR(NR), .ZERO_REG(1), .BYPASS(1)) dut (
      .clk(clk), .reset(reset), .we(we), .wad(wad), .din(din), .rad(rad),
      .dout(dout), .clr_start(clr_start), .busy(busy), .wr_drop(wr_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // What the model says a read of addr should return right now
   function automatic logic [W-1:0] exp_read(input logic [M-1:0] a);
      if (a == 4'd0) return 16'h0000;
      if (we && clr_left == 0 && a == wad) return din;
      return mem_m[a];
   endfunction

   task automatic model_edge();
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'h0000;
         clr_left = 0;
         drop_m   = 1'b0;
      end else begin
         drop_m = we && (clr_left > 0);
         if (clr_left > 0) begin
            mem_m[DEPTH - clr_left] = 16'h0000;
            clr_left--;
         end else begin
            if (we && wad != 4'd0) mem_m[wad] = din;
            if (clr_start) clr_left = DEPTH;
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string name);
      for (int p = 0; p < NR; p++) begin
         chk($sformatf("%s dout%0d", name, p), 64'(dout[p*W +: W]), 64'(exp_read(rad[p*M +: M])));
      end
      chk({name, " busy"}, 64'(busy), 64'(clr_left > 0));
      chk({name, " wr_drop"}, 64'(wr_drop), 64'(drop_m));
   endtask

   task automatic check_all_zero(input string name);
      we = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
         rad = {4'(a), 4'(a), 4'(a)};
         #1;
         chk($sformatf("%s addr%0d", name, a), 64'(dout[W-1:0]), 64'h0);
      end
   endtask

   task automatic fill();
      for (int a = 0; a < DEPTH; a++) begin
         we = 1'b1; wad = 4'(a); din = 16'(a + 1);
         tick();
      end
      we = 1'b0;
   endtask

   typedef struct {
      logic          we;
      logic [M-1:0]  wad;
      logic [W-1:0]  din;
      logic [11:0]   rad;
      logic [47:0]   exp;
   } vec_t;

   vec_t tbl [7];
   int   blen;

   initial begin
      tbl[0] = '{1'b1, 4'd5, 16'hA5A5, {4'd15, 4'd7, 4'd3}, 48'h0000_0000_0000};
      tbl[1] = '{1'b1, 4'd9, 16'h1234, {4'd5, 4'd9, 4'd5},  48'hA5A5_1234_A5A5};
      tbl[2] = '{1'b0, 4'd0, 16'h0000, {4'd5, 4'd9, 4'd5},  48'hA5A5_1234_A5A5};
      tbl[3] = '{1'b1, 4'd0, 16'hFFFF, {4'd0, 4'd0, 4'd0},  48'h0000_0000_0000};
      tbl[4] = '{1'b0, 4'd0, 16'h0000, {4'd0, 4'd0, 4'd0},  48'h0000_0000_0000};
      tbl[5] = '{1'b1, 4'd6, 16'hBEEF, {4'd0, 4'd6, 4'd9},  48'h0000_BEEF_1234};
      tbl[6] = '{1'b0, 4'd0, 16'h0000, {4'd6, 4'd5, 4'd9},  48'hBEEF_A5A5_1234};

      reset = 1'b1; we = 1'b0; wad = 4'd0; din = 16'h0; rad = 12'h0; clr_start = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'h0000;
      clr_left = 0; drop_m = 1'b0;
      tick();
      reset = 1'b0;
      rad = {4'd15, 4'd7, 4'd3};
      #1;
      chk("reset dout", 64'(dout), 64'h0);
      chk("reset busy", 64'(busy), 64'h0);
      chk("reset wr_drop", 64'(wr_drop), 64'h0);

      // Directed table: write/read, zero register, bypass
      for (int v = 0; v < 7; v++) begin
         we = tbl[v].we; wad = tbl[v].wad; din = tbl[v].din; rad = tbl[v].rad;
         #1;
         chk($sformatf("vec%0d dout", v), 64'(dout), 64'(tbl[v].exp));
         check_model($sformatf("vec%0d", v));
         tick();
      end
      we = 1'b0;

      // Plain clear: busy length and half-way contents
      fill();
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      blen = busy ? 1 : 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k == 8) begin
            rad = {4'd7, 4'd8, 4'd7};
            #1;
            chk("clr8 addr7", 64'(dout[W-1:0]), 64'h0);
            chk("clr8 addr8", 64'(dout[2*W-1:W]), 64'd9);
            check_model("clr8");
         end
         if (busy) blen++;
         else break;
      end
      chk("clear busy length", 64'(blen), 64'd16);
      check_all_zero("after clear");

      // Clear with a dropped write and an ignored restart
      fill();
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      blen = busy ? 1 : 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         we = 1'b0; clr_start = 1'b0;
         if (k == 3) begin we = 1'b1; wad = 4'd12; din = 16'h00FF; end
         if (k == 4) chk("drop pulse", 64'(wr_drop), 64'h1);
         if (k == 5) chk("drop one cycle", 64'(wr_drop), 64'h0);
         if (k == 6) clr_start = 1'b1;
         rad = {4'd12, 4'd13, 4'd14};
         #1;
         check_model($sformatf("wclr k%0d", k));
         if (busy) blen++;
         else break;
      end
      we = 1'b0; clr_start = 1'b0;
      chk("restart busy length", 64'(blen), 64'd16);
      rad = {4'd12, 4'd12, 4'd12};
      #1;
      chk("addr12 after clear", 64'(dout[W-1:0]), 64'h0);

      // Reset in the middle of a clear
      fill();
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      rad = {4'd10, 4'd15, 4'd12};
      #1;
      chk("pre-reset addr15", 64'(dout[2*W-1:W]), 64'd16);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid reset busy", 64'(busy), 64'h0);
      check_all_zero("mid reset");
      we = 1'b1; wad = 4'd3; din = 16'h3C3C;
      tick();
      we = 1'b0; rad = {4'd3, 4'd3, 4'd3};
      #1;
      chk("post reset wr_drop", 64'(wr_drop), 64'h0);
      chk("post reset addr3", 64'(dout[W-1:0]), 64'h3C3C);

      // Randomised traffic against the model
      for (int c = 0; c < 600; c++) begin
         reset     = ($urandom_range(0, 99) == 0);
         clr_start = ($urandom_range(0, 24) == 0);
         we        = $urandom_range(0, 1);
         wad       = 4'($urandom_range(0, 15));
         din       = 16'($urandom);
         rad       = 12'($urandom);
         if ($urandom_range(0, 3) == 0) rad[7:4] = wad;
         #1;
         check_model("rand");
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
